mm_burst_arbiter: RTL and testbench

- Shares the single-ported main-memory word interface between three line-burst requesters: D-cache writeback, D-cache refill and I-cache refill.
- Sequences each granted request as a WORDS_PER_LINE-word burst, one main-memory access per word.
- Steers refill words back to the winning requester, and pulls writeback words from the D-cache side.
- Sits between the cache controller and main memory, and replaces direct cache-line-adapter drive of the memory port.

---
 rtl/mm_burst_arbiter_if.sv | 65 ++++++
 rtl/mm_burst_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mm_burst_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_burst_arbiter_if.sv
// mm_burst_arbiter_if: requester and main-memory bundle for mm_burst_arbiter.
// master = arbiter side; slave = requesters plus memory (the environment).
interface mm_burst_arbiter_if #(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_SIZE      = 32
);
  localparam int LW = $clog2(WORDS_PER_LINE);

  // D-cache writeback requester
  logic                 req_wb;
  logic [ADDR_SIZE-1:0] addr_wb;
  logic [WORD_SIZE-1:0] wb_data;
  logic                 wb_next;
  logic                 done_wb;

  // D-cache refill requester
  logic                 req_d;
  logic [ADDR_SIZE-1:0] addr_d;
  logic                 fill_vld_d;
  logic                 done_d;

  // I-cache refill requester
  logic                 req_i;
  logic [ADDR_SIZE-1:0] addr_i;
  logic                 fill_vld_i;
  logic                 done_i;

  // shared refill return path
  logic [WORD_SIZE-1:0] fill_data;
  logic [LW-1:0]        fill_word;
  logic [1:0]           grant;

  // main-memory word port
  logic                 mm_re;
  logic                 mm_we;
  logic [ADDR_SIZE-3:0] mm_addr;
  logic [WORD_SIZE-1:0] mm_din;
  logic [WORD_SIZE-1:0] mm_dout;
  logic                 mm_valid;

  modport master (
    input  req_wb, addr_wb, wb_data,
    input  req_d, addr_d,
    input  req_i, addr_i,
    input  mm_dout, mm_valid,
    output wb_next, done_wb,
    output fill_vld_d, done_d,
    output fill_vld_i, done_i,
    output fill_data, fill_word, grant,
    output mm_re, mm_we, mm_addr, mm_din
  );

  modport slave (
    output req_wb, addr_wb, wb_data,
    output req_d, addr_d,
    output req_i, addr_i,
    output mm_dout, mm_valid,
    input  wb_next, done_wb,
    input  fill_vld_d, done_d,
    input  fill_vld_i, done_i,
    input  fill_data, fill_word, grant,
    input  mm_re, mm_we, mm_addr, mm_din
  );
endinterface

// File: rtl/mm_burst_arbiter.sv
// mm_burst_arbiter: shares one main-memory word port between D-cache
// writeback, D-cache refill and I-cache refill, one line burst at a time.
// Ports: MEM_CLK (rising edge), RST (async, active high), bus (master
// modport): level requests + line addresses in, wb_next/fill_* pulses and
// done_* pulses out, grant (00 none, 01 I, 10 D, 11 WB), and the
// mm_re/mm_we/mm_addr/mm_din/mm_dout/mm_valid memory word port.
module mm_burst_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_SIZE      = 32
) (
  input logic                MEM_CLK,
  input logic                RST,
  mm_burst_arbiter_if.master bus
);

  localparam int LW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = LW + 2;
  localparam int BW  = ADDR_SIZE - OFF;

  localparam logic [LW-1:0] LAST =
    LW'(WORDS_PER_LINE - 1);

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_I    = 2'b01;
  localparam logic [1:0] G_D    = 2'b10;
  localparam logic [1:0] G_WB   = 2'b11;

  if (WORDS_PER_LINE < 2 ||
      (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0)
  begin : g_bad_words
    $error("WORDS_PER_LINE must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    GAP,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_n;
  logic [BW-1:0] base;
  logic [BW-1:0] base_n;
  logic [1:0]    grant;
  logic [1:0]    grant_n;
  // rr = 0 favours I, rr = 1 favours D
  logic          rr;
  logic          rr_n;

  logic pick_wb;
  logic pick_d;
  logic pick_i;
  logic acc;
  logic is_wb;
  logic hit;
  logic rd_hit;
  logic in_done;

  // line-offset bits of the request addresses carry no information
  logic unused_off;
  assign unused_off = ^{bus.addr_wb[OFF-1:0],
                        bus.addr_d[OFF-1:0],
                        bus.addr_i[OFF-1:0]};

  // writeback always wins so a victim leaves before its refill
  always_comb begin
    pick_wb = bus.req_wb;
    pick_d  = !bus.req_wb && bus.req_d &&
              (!bus.req_i || rr);
    pick_i  = !bus.req_wb && bus.req_i &&
              (!bus.req_d || !rr);
  end

  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      grant <= G_NONE;
      rr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      base  <= base_n;
      grant <= grant_n;
      rr    <= rr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    base_n  = base;
    grant_n = grant;
    rr_n    = rr;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_wb: begin
            grant_n = G_WB;
            base_n  = bus.addr_wb[ADDR_SIZE-1:OFF];
          end
          pick_d: begin
            grant_n = G_D;
            base_n  = bus.addr_d[ADDR_SIZE-1:OFF];
          end
          pick_i: begin
            grant_n = G_I;
            base_n  = bus.addr_i[ADDR_SIZE-1:OFF];
          end
          default: ;
        endcase
        if (pick_wb || pick_d || pick_i) begin
          cnt_n   = '0;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mm_valid) begin
          // counter parks on the last word; only a
          // new grant brings it back to zero
          if (cnt == LAST) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt + LW'(1);
            state_n = GAP;
          end
        end
      end
      GAP: begin
        state_n = ACCESS;
      end
      DONE: begin
        state_n = IDLE;
        grant_n = G_NONE;
        if (grant == G_I) begin
          rr_n = 1'b1;
        end else if (grant == G_D) begin
          rr_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    acc     = (state == ACCESS);
    in_done = (state == DONE);
    is_wb   = (grant == G_WB);
    hit     = acc && bus.mm_valid;
    rd_hit  = hit && !is_wb;
  end

  // memory side: held stable for the whole access
  always_comb begin
    bus.mm_re   = acc && !is_wb;
    bus.mm_we   = acc && is_wb;
    bus.mm_addr = acc ? {base, cnt} : '0;
    bus.mm_din  = (acc && is_wb) ?
                  bus.wb_data : '0;
  end

  // return path: combinational in the mm_valid cycle
  always_comb begin
    bus.fill_data  = rd_hit ? bus.mm_dout : '0;
    bus.fill_word  = rd_hit ? cnt : '0;
    bus.fill_vld_d = hit && (grant == G_D);
    bus.fill_vld_i = hit && (grant == G_I);
    bus.wb_next    = hit && is_wb;
  end

  always_comb begin
    bus.done_wb = in_done && (grant == G_WB);
    bus.done_d  = in_done && (grant == G_D);
    bus.done_i  = in_done && (grant == G_I);
    bus.grant   = grant;
  end

  a_re_we_excl: assert property (
    @(posedge MEM_CLK) disable iff (RST)
    !(bus.mm_re && bus.mm_we)
  );

endmodule

// File: tb/tb_mm_burst_arbiter.sv
// tb_mm_burst_arbiter: table of burst scenarios plus reset and stall
// sequences; a word/done scoreboard checks everything the arbiter emits.
module tb_mm_burst_arbiter;

  localparam int W  = 8;
  localparam int WS = 32;
  localparam int AS = 32;

  localparam logic [1:0] G_N  = 2'b00;
  localparam logic [1:0] G_I  = 2'b01;
  localparam logic [1:0] G_D  = 2'b10;
  localparam logic [1:0] G_WB = 2'b11;

  typedef struct {
    logic [1:0]  g;
    logic [29:0] addr;
    logic [2:0]  word;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] awb;
    logic [31:0] ad;
    logic [31:0] ai;
    int          n_wb;
    int          n_d;
    int          n_i;
    int          lat;
    bit          spur;
    int          ng;
    logic [7:0]  gseq;
  } vec_t;

  logic MEM_CLK = 1'b0;
  logic RST     = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  mm_burst_arbiter_if #(
    .WORDS_PER_LINE(W), .WORD_SIZE(WS), .ADDR_SIZE(AS)
  ) bus ();

  mm_burst_arbiter #(
    .WORDS_PER_LINE(W), .WORD_SIZE(WS), .ADDR_SIZE(AS)
  ) dut (
    .MEM_CLK(MEM_CLK),
    .RST    (RST),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  exp_t       q[$];
  logic [1:0] dq[$];

  int launch_wb = 0;
  int launch_d  = 0;
  int launch_i  = 0;
  int served_wb = 0;
  int served_d  = 0;
  int served_i  = 0;

  int lat    = 1;
  bit spur   = 1'b0;
  int wb_idx = 0;
  int wait_n = 0;

  logic        m_acc;
  logic        m_hit;
  logic [2:0]  m_dn;
  exp_t        m_e;
  logic [1:0]  m_dg;
  logic        prev_acc = 1'b0;
  logic        prev_hit = 1'b0;
  logic        prev_gap = 1'b0;
  logic [29:0] prev_addr;
  logic        prev_re;
  logic        prev_we;
  logic [31:0] prev_din;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return {21'd0, bus.wb_next, bus.fill_data,
            bus.fill_word, bus.fill_vld_d,
            bus.fill_vld_i, bus.done_wb, bus.done_d,
            bus.done_i, bus.grant, bus.mm_re,
            bus.mm_we, bus.mm_addr, bus.mm_din};
  endfunction

  function automatic vec_t mk(
    input string nm, input logic [31:0] awb,
    input logic [31:0] ad, input logic [31:0] ai,
    input int nwb, input int nd, input int ni,
    input int lt, input bit sp, input int ng,
    input logic [7:0] gs);
    vec_t v;
    v.name = nm;  v.awb = awb; v.ad = ad; v.ai = ai;
    v.n_wb = nwb; v.n_d = nd;  v.n_i = ni;
    v.lat  = lt;  v.spur = sp; v.ng = ng; v.gseq = gs;
    return v;
  endfunction

  // expected words of one line burst, in issue order
  task automatic push_burst(input logic [1:0] g,
                            input logic [31:0] a);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      e.g    = g;
      e.addr = {a[31:5], 3'(k)};
      e.word = 3'(k);
      e.data = (g == G_WB) ? 32'hA500_0000 + 32'(k)
                           : {2'b00, a[31:5], 3'(k)};
      q.push_back(e);
    end
  endtask

  // memory + writeback-data model, updated just after each edge
  always @(posedge MEM_CLK) begin
    #1;
    bus.wb_data = 32'hA500_0000 + 32'(wb_idx);
    if (RST) begin
      wait_n       = 0;
      bus.mm_valid = 1'b0;
      bus.mm_dout  = '0;
    end else if (bus.mm_re || bus.mm_we) begin
      wait_n++;
      bus.mm_valid = (wait_n == lat);
      bus.mm_dout  = {2'b00, bus.mm_addr};
    end else begin
      wait_n       = 0;
      bus.mm_valid = spur;
      bus.mm_dout  = spur ? 32'hDEAD_BEEF : 32'h0;
    end
  end

  // monitor, scoreboard and request drivers
  always @(negedge MEM_CLK) begin
    m_acc = bus.mm_re | bus.mm_we;
    m_hit = m_acc & bus.mm_valid;
    m_dn  = {bus.done_wb, bus.done_d, bus.done_i};
    if (RST) begin
      prev_acc = 1'b0;
      prev_hit = 1'b0;
      prev_gap = 1'b0;
    end else begin
      chk("re_we_excl", 128'(bus.mm_re & bus.mm_we), 0);
      if (m_acc && prev_acc && !prev_hit)
        chk("access_hold",
            {bus.mm_addr, bus.mm_re, bus.mm_we, bus.mm_din},
            {prev_addr, prev_re, prev_we, prev_din});
      if (prev_hit)
        chk("gap_enables", 128'(m_acc), 0);
      if (prev_gap)
        chk("gap_one_cycle", 128'(m_acc), 1);
      if (!m_hit)
        chk("no_spurious_pulse",
            {bus.fill_vld_d, bus.fill_vld_i, bus.wb_next}, 0);
      if (m_hit) begin
        if (q.size() == 0) begin
          chk("unexpected_access", {bus.grant, bus.mm_addr}, 0);
        end else begin
          m_e = q.pop_front();
          chk("word_grant", bus.grant, m_e.g);
          chk("mm_addr", bus.mm_addr, m_e.addr);
          chk("pulses",
              {bus.fill_vld_d, bus.fill_vld_i, bus.wb_next},
              (m_e.g == G_D) ? 3'b100 :
              (m_e.g == G_I) ? 3'b010 : 3'b001);
          if (m_e.g == G_WB) begin
            chk("mm_din", bus.mm_din, m_e.data);
          end else begin
            chk("fill_data", bus.fill_data, m_e.data);
            chk("fill_word", bus.fill_word, m_e.word);
          end
        end
        if (bus.wb_next) wb_idx++;
      end
      if (m_dn != 3'b000) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", m_dn, 0);
        end else begin
          m_dg = dq.pop_front();
          chk("done_pulse", m_dn,
              (m_dg == G_WB) ? 3'b100 :
              (m_dg == G_D)  ? 3'b010 : 3'b001);
          chk("done_grant", bus.grant, m_dg);
        end
        if (bus.done_wb) begin
          served_wb++;
          wb_idx = 0;
        end
        if (bus.done_d) served_d++;
        if (bus.done_i) served_i++;
      end
      prev_gap  = prev_hit && (m_dn == 3'b000);
      prev_hit  = m_hit;
      prev_acc  = m_acc;
      prev_addr = bus.mm_addr;
      prev_re   = bus.mm_re;
      prev_we   = bus.mm_we;
      prev_din  = bus.mm_din;
    end
    // requesters drop req in the done cycle, re-raise if more lines wanted
    bus.req_wb = (served_wb < launch_wb) && !bus.done_wb;
    bus.req_d  = (served_d  < launch_d)  && !bus.done_d;
    bus.req_i  = (served_i  < launch_i)  && !bus.done_i;
  end

  task automatic wait_drain(input string nm);
    int cyc;
    cyc = 0;
    while ((q.size() != 0 || dq.size() != 0) && cyc < 3000) begin
      @(negedge MEM_CLK);
      cyc++;
    end
    #1;
    if (cyc >= 3000) begin
      chk({nm, ":timeout"}, 128'(q.size() + dq.size()), 0);
      q.delete();
      dq.delete();
      launch_wb = served_wb;
      launch_d  = served_d;
      launch_i  = served_i;
    end
  endtask

  task automatic run_row(input vec_t v);
    logic [1:0] g;
    @(negedge MEM_CLK);
    #1;
    lat = v.lat;
    spur = v.spur;
    bus.addr_wb = v.awb;
    bus.addr_d  = v.ad;
    bus.addr_i  = v.ai;
    repeat (3) begin
      @(negedge MEM_CLK);
      #1;
      chk({v.name, ":idle_grant"}, bus.grant, G_N);
      chk({v.name, ":idle_en"}, {bus.mm_re, bus.mm_we}, 0);
    end
    for (int k = 0; k < v.ng; k++) begin
      g = v.gseq[2*k +: 2];
      dq.push_back(g);
      push_burst(g, (g == G_WB) ? v.awb :
                    (g == G_D)  ? v.ad  : v.ai);
    end
    launch_wb += v.n_wb;
    launch_d  += v.n_d;
    launch_i  += v.n_i;
    wait_drain(v.name);
    repeat (2) @(negedge MEM_CLK);
    #1;
    chk({v.name, ":end_grant"}, bus.grant, G_N);
    spur = 1'b0;
  endtask

  task automatic reset_mid_burst();
    int cyc;
    @(negedge MEM_CLK);
    #1;
    lat = 3;
    spur = 1'b0;
    bus.addr_d = 32'h0000_0200;
    dq.push_back(G_D);
    push_burst(G_D, 32'h0000_0200);
    launch_d++;
    cyc = 0;
    while (!(bus.mm_re && bus.mm_addr[2:0] == 3'd3) &&
           cyc < 500) begin
      @(negedge MEM_CLK);
      cyc++;
    end
    chk("rst:reach_word3", 128'(cyc < 500), 1);
    #2 RST = 1'b1;
    #1;
    chk("rst:async_outputs", all_out(), 0);
    chk("rst:words_left", 128'(q.size()), 5);
    q.delete();
    push_burst(G_D, 32'h0000_0200);
    @(negedge MEM_CLK);
    #2 RST = 1'b0;
    wait_drain("rst");
    chk("rst:served_d", 128'(served_d), 128'(launch_d));
  endtask

  initial begin
    tbl[0] = mk("i_alone", 0, 0, 32'h0000_0124,
                0, 0, 1, 1, 1'b0, 1, 8'h01);
    tbl[1] = mk("wb_then_d", 32'h0000_6040, 32'h0000_7040, 0,
                1, 1, 0, 2, 1'b0, 2, 8'b0000_1011);
    tbl[2] = mk("round_robin", 0, 32'h0000_0A00, 32'h0000_0B00,
                0, 2, 2, 1, 1'b0, 4, 8'b1001_1001);
    tbl[3] = mk("stall7", 0, 32'h0000_1F00, 0,
                0, 1, 0, 7, 1'b0, 1, 8'h02);
    tbl[4] = mk("wb_top", 32'hFFFF_FFE4, 0, 0,
                1, 0, 0, 3, 1'b0, 1, 8'h03);
    tbl[5] = mk("all_three", 32'h0000_0100, 32'h0000_0200,
                32'h0000_0300, 1, 1, 1, 1, 1'b0, 3,
                8'b0010_0111);
    tbl[6] = mk("spurious", 0, 0, 32'h0000_0FE0,
                0, 0, 1, 2, 1'b1, 1, 8'h01);

    bus.addr_wb = '0;
    bus.addr_d  = '0;
    bus.addr_i  = '0;
    #1 RST = 1'b1;
    repeat (2) @(negedge MEM_CLK);
    #1;
    chk("reset_outputs", all_out(), 0);
    #1 RST = 1'b0;

    for (int r = 0; r < 7; r++) run_row(tbl[r]);
    reset_mid_burst();

    repeat (3) @(negedge MEM_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
